// File: rtl/maxpool_sched.sv
// Round-robin scheduler that shares one serial maxpool datapath between NO_SRC streams and tags each result.
// Optional stall watchdog is enabled by defining MAXPOOL_SCHED_WDOG_EN.
module maxpool_sched #(
  parameter int NO_SRC    = 4,
  parameter int NO_CH     = 10,
  parameter int BW_IN     = 12,
  parameter int SER_BW    = 4,
  parameter int MP_LAT    = 3,
  parameter int TAG_DEP   = 4,
  parameter int STALL_MAX = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NO_SRC-1:0]                req_vld,
  input  logic [NO_SRC*NO_CH*SER_BW-1:0]   req_data,
  output logic [NO_SRC-1:0]                req_rdy,
  output logic                             mp_vld_in,
  output logic [NO_CH*SER_BW-1:0]          mp_data_in,
  input  logic                             mp_vld_out,
  input  logic [NO_CH*BW_IN-1:0]           mp_data_out,
  output logic                             out_vld,
  output logic [NO_CH*BW_IN-1:0]           out_data,
  output logic [$clog2(NO_SRC)-1:0]        out_src,
  output logic                             err
);

  localparam int BUF_CYC = 2 * BW_IN / SER_BW;
  localparam int SW      = $clog2(NO_SRC);
  localparam int DW      = NO_CH * SER_BW;
  localparam int CW      = $clog2(BUF_CYC);
  localparam int AW      = $clog2(TAG_DEP);
  localparam logic [AW:0] PTR_ONE = 1;

  if (NO_SRC < 2 || (2 * BW_IN) % SER_BW != 0 || TAG_DEP < MP_LAT / (BUF_CYC + 1) + 2 ||
      STALL_MAX < 1) begin : g_cfg_err
    $error("maxpool_sched: illegal parameter set");
  end

  typedef enum logic {ARB, BURST} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   rr_ptr, grant, arb_sel, grant_inc;
  logic            arb_hit;
  logic [CW-1:0]   beat_cnt;
  logic            xfer, last_xfer;
  logic            wdog_trip;

  // Search from rr_ptr upward with wrap; the first requesting source wins.
  always_comb begin : arb_search
    int            idx;
    logic [SW-1:0] idx_s;
    arb_hit = 1'b0;
    arb_sel = '0;
    for (int k = 0; k < NO_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NO_SRC) idx = idx - NO_SRC;
      idx_s = SW'(idx);
      if (!arb_hit && req_vld[idx_s]) begin
        arb_hit = 1'b1;
        arb_sel = idx_s;
      end
    end
  end

  assign grant_inc = (grant == SW'(NO_SRC - 1)) ? '0 : grant + SW'(1);

  // Handshake: a beat of source i moves on any cycle with req_vld[i] && req_rdy[i];
  // req_rdy is combinational, only the granted source sees it, and it is low in ARB and during rst.
  always_comb begin
    state_nxt  = state;
    req_rdy    = '0;
    mp_vld_in  = 1'b0;
    xfer       = 1'b0;
    last_xfer  = 1'b0;
    mp_data_in = req_data[int'(grant)*DW +: DW];
    if (!rst) begin
      case (state)
        ARB: begin
          if (arb_hit) state_nxt = BURST;
        end
        BURST: begin
          xfer           = req_vld[grant];
          req_rdy[grant] = req_vld[grant];
          mp_vld_in      = req_vld[grant];
          if (xfer && beat_cnt == CW'(BUF_CYC - 1)) begin
            last_xfer = 1'b1;
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && arb_hit) grant <= arb_sel;
      if (last_xfer) begin
        beat_cnt <= '0;
        rr_ptr   <= grant_inc;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

  // Tag FIFO: one entry per completed pair, consumed when maxpool emits its result.
  logic [SW-1:0] tag_mem [TAG_DEP];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = mp_vld_out && !fifo_empty;
  assign push       = last_xfer && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr[AW-1:0]] <= grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      err      <= 1'b0;
    end else begin
      out_vld <= mp_vld_out;
      if (mp_vld_out) begin
        out_data <= mp_data_out;
        out_src  <= fifo_empty ? '0 : tag_mem[rd_ptr[AW-1:0]];
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if ((last_xfer && !push) || (mp_vld_out && fifo_empty) || wdog_trip) err <= 1'b1;
    end
  end

`ifdef MAXPOOL_SCHED_WDOG_EN
  localparam int STW = $clog2(STALL_MAX + 1);
  logic [STW-1:0] stall_cnt;

  // Counts consecutive starved BURST cycles; flags once, the burst itself carries on.
  always_ff @(posedge clk) begin
    if (rst || state != BURST || xfer) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STW'(STALL_MAX)) begin
      stall_cnt <= stall_cnt + STW'(1);
    end
  end

  assign wdog_trip = !rst && (state == BURST) && !xfer && (stall_cnt == STW'(STALL_MAX - 1));
`else
  assign wdog_trip = 1'b0;
`endif

endmodule
